direct_mapped_cache: RTL and testbench

- Parameterised direct-mapped cache: one line per index, NUM_OF_BLOCKS_PER_LINE blocks of BLOCK_SIZE bits each.
- Sits between a requester (block-granular read/write) and a fill controller, which loads whole lines via write_line.
- Reports hit/miss per request and tracks valid/dirty per line. No write-allocate and no internal writeback; miss handling belongs to the external controller.

---
 rtl/direct_mapped_cache_pkg.sv | 33 +++
 rtl/direct_mapped_cache_store.sv | 22 ++
 rtl/direct_mapped_cache.sv | 98 +++++++++
 tb/tb_direct_mapped_cache.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/direct_mapped_cache_pkg.sv
// Shared widths, line-record layout and address split for the default cache geometry.
package direct_mapped_cache_pkg;
    localparam int DEF_BLOCK_SIZE = 4;
    localparam int DEF_BLOCKS     = 2;
    localparam int DEF_LINES      = 4;
    localparam int DEF_ADDR_SIZE  = 16;

    localparam int OFFSET    = $clog2(DEF_BLOCKS);
    localparam int INDEX     = $clog2(DEF_LINES);
    localparam int TAG       = DEF_ADDR_SIZE - OFFSET - INDEX;
    localparam int DATA_W    = DEF_BLOCKS * DEF_BLOCK_SIZE;
    localparam int LINE_W    = 2 + TAG + DATA_W;
    localparam int DIRTY_BIT = LINE_W - 1;
    localparam int VALID_BIT = LINE_W - 2;
    localparam int TAG_LSB   = DATA_W;

    typedef struct packed {
        logic              dirty;
        logic              valid;
        logic [TAG-1:0]    tag;
        logic [DATA_W-1:0] data;
    } line_t;

    typedef struct packed {
        logic [TAG-1:0]    tag;
        logic [INDEX-1:0]  index;
        logic [OFFSET-1:0] offset;
    } addr_t;

    function automatic addr_t split_addr(input logic [DEF_ADDR_SIZE-1:0] a);
        return addr_t'(a);
    endfunction
endpackage

// File: rtl/direct_mapped_cache_store.sv
// Line array for the cache: one write port, combinational read, async clear.
module direct_mapped_cache_store #(
    parameter  int LINE_W = 23,
    parameter  int LINES  = 4,
    localparam int IDX_W  = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wline_i,
    output logic [LINE_W-1:0] rline_o
);
    logic [LINES-1:0][LINE_W-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    mem_q <= '0;
        else if (we_i) mem_q[idx_i] <= wline_i;
    end

    assign rline_o = mem_q[idx_i];
endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped block cache: block read/write plus full-line fill, registered hit/miss/data.
module direct_mapped_cache
    import direct_mapped_cache_pkg::*;
#(
    parameter int BLOCK_SIZE             = DEF_BLOCK_SIZE,
    parameter int NUM_OF_BLOCKS_PER_LINE = DEF_BLOCKS,
    parameter int NUM_OF_CACHE_LINES     = DEF_LINES,
    parameter int ADDRESS_SIZE           = DEF_ADDR_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     read,
    input  logic                                     write,
    input  logic                                     write_line,
    input  logic [ADDRESS_SIZE-1:0]                  address,
    input  logic [BLOCK_SIZE-1:0]                    data_i,
    input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_i,
    output logic [BLOCK_SIZE-1:0]                    data_o,
    output logic                                     hit,
    output logic                                     miss
);
    localparam int OFF_W  = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_OF_CACHE_LINES);
    localparam int TAG_W  = ADDRESS_SIZE - OFF_W - IDX_W;
    localparam int DAT_W  = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
    localparam int LN_W   = 2 + TAG_W + DAT_W;

    typedef struct packed {
        logic             dirty;
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DAT_W-1:0] data;
    } cline_t;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    assign {a_tag, a_idx, a_off} = address;

    cline_t rline, wline;
    logic   we, match;
    logic   hit_q, hit_d, miss_q, miss_d;
    logic [BLOCK_SIZE-1:0] data_q, data_d;

    direct_mapped_cache_store #(.LINE_W(LN_W), .LINES(NUM_OF_CACHE_LINES)) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we),
        .idx_i  (a_idx),
        .wline_i(wline),
        .rline_o(rline)
    );

    assign match = rline.valid && (rline.tag == a_tag);

    // One request per edge: fill beats write beats read; outputs hold when idle.
    always_comb begin
        wline  = rline;
        we     = 1'b0;
        hit_d  = hit_q;
        miss_d = miss_q;
        data_d = data_q;
        if (write_line) begin
            we     = 1'b1;
            wline  = '{dirty: 1'b0, valid: 1'b1, tag: a_tag, data: line_i};
            hit_d  = 1'b1;
            miss_d = 1'b0;
        end else if (write) begin
            hit_d  = match;
            miss_d = !match;
            if (match) begin
                we = 1'b1;
                wline.dirty = 1'b1;
                wline.data[a_off*BLOCK_SIZE +: BLOCK_SIZE] = data_i;
            end
        end else if (read) begin
            hit_d  = match;
            miss_d = !match;
            data_d = match ? rline.data[a_off*BLOCK_SIZE +: BLOCK_SIZE] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            data_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            data_q <= data_d;
        end
    end

    assign hit    = hit_q;
    assign miss   = miss_q;
    assign data_o = data_q;
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: directed vector table, mid-cycle reset, random ops vs. a block-level model.
module tb_direct_mapped_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0, write = 1'b0, write_line = 1'b0;
    logic [15:0] address = '0;
    logic [3:0]  data_i = '0;
    logic [7:0]  line_i = '0;
    logic [3:0]  data_o;
    logic        hit, miss;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    direct_mapped_cache dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .write_line(write_line),
        .address(address), .data_i(data_i), .line_i(line_i),
        .data_o(data_o), .hit(hit), .miss(miss)
    );

    typedef struct {
        logic        rst;
        logic        rd, wr, wl;
        logic [15:0] addr;
        logic [3:0]  din;
        logic [7:0]  ln;
        logic        eh, em;
        logic [3:0]  ed;
    } vec_t;

    // Reference model: per-line valid/tag and an array of blocks.
    bit          m_valid [4];
    int          m_tag   [4];
    logic [3:0]  m_blk   [4][2];
    logic        m_hit, m_miss;
    logic [3:0]  m_data;

    task automatic check(input string name, input logic eh, input logic em, input logic [3:0] ed);
        checks++;
        if (hit !== eh || miss !== em || data_o !== ed) begin
            errors++;
            $display("FAIL %s: got hit=%0b miss=%0b data=%h, want hit=%0b miss=%0b data=%h",
                     name, hit, miss, data_o, eh, em, ed);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset", 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic wl,
                         input logic [15:0] a, input logic [3:0] din, input logic [7:0] ln);
        @(negedge clk);
        read = rd; write = wr; write_line = wl;
        address = a; data_i = din; line_i = ln;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0; write_line = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_blk[i][0] = '0; m_blk[i][1] = '0;
        end
        m_hit = 0; m_miss = 0; m_data = '0;
    endtask

    task automatic model_op(input logic rd, input logic wr, input logic wl,
                            input logic [15:0] a, input logic [3:0] din, input logic [7:0] ln);
        int off, idx, tg;
        bit hitm;
        off  = a % 2;
        idx  = (a / 2) % 4;
        tg   = a / 8;
        hitm = m_valid[idx] && m_tag[idx] == tg;
        if (wl) begin
            m_valid[idx] = 1; m_tag[idx] = tg;
            m_blk[idx][0] = ln[3:0]; m_blk[idx][1] = ln[7:4];
            m_hit = 1; m_miss = 0;
        end else if (wr) begin
            m_hit = hitm; m_miss = !hitm;
            if (hitm) m_blk[idx][off] = din;
        end else if (rd) begin
            m_hit = hitm; m_miss = !hitm;
            m_data = hitm ? m_blk[idx][off] : 4'h0;
        end
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rd, input logic wr, input logic wl,
                                input logic [15:0] a, input logic [3:0] din, input logic [7:0] ln,
                                input logic eh, input logic em, input logic [3:0] ed);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.wl = wl; v.addr = a; v.din = din; v.ln = ln;
        v.eh = eh; v.em = em; v.ed = ed;
        return v;
    endfunction

    initial begin
        //            rst rd wr wl addr     din   line   hit miss data
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 0, 4'h0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 4'hA, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 4'h0, 8'h5C, 1, 0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 4'h0, 8'h00, 1, 0, 4'hC));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0001, 4'h0, 8'h00, 1, 0, 4'h5));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0008, 4'h0, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 4'h0, 8'h00, 1, 0, 4'hC));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0001, 4'h3, 8'h00, 1, 0, 4'hC));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0001, 4'h0, 8'h00, 1, 0, 4'h3));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0008, 4'h0, 8'h77, 1, 0, 4'h3));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 4'h0, 8'h00, 0, 1, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0008, 4'h0, 8'h00, 1, 0, 4'h7));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0002, 4'h0, 8'h9E, 1, 0, 4'h7));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0002, 4'h0, 8'h00, 1, 0, 4'hE));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0003, 4'h1, 8'h00, 1, 0, 4'hE));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0003, 4'h0, 8'h00, 1, 0, 4'h1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h000A, 4'h0, 8'h00, 0, 1, 4'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            else begin
                do_op(vecs[i].rd, vecs[i].wr, vecs[i].wl, vecs[i].addr, vecs[i].din, vecs[i].ln);
                check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].ed);
            end
        end

        // Reset pulled low while a read is pending, before its clock edge.
        @(negedge clk);
        read = 1'b1; address = 16'h0002;
        #2 rst_n = 1'b0;
        #1 check("midreset", 1'b0, 1'b0, 4'h0);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 0, 0, 16'h0002, 4'h0, 8'h00);
        check("after_midreset", 1'b0, 1'b1, 4'h0);

        // Random ops against the model; small tag range so hits are common.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic rd, wr, wl;
            logic [15:0] a;
            logic [3:0]  din;
            logic [7:0]  ln;
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
                model_reset();
                continue;
            end
            rd  = ($urandom_range(0, 1) == 1);
            wr  = ($urandom_range(0, 2) == 0);
            wl  = ($urandom_range(0, 4) == 0);
            a   = 16'($urandom_range(0, 31));
            din = 4'($urandom);
            ln  = 8'($urandom);
            do_op(rd, wr, wl, a, din, ln);
            model_op(rd, wr, wl, a, din, ln);
            check($sformatf("rand%0d", n), m_hit, m_miss, m_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
